time_edit_ctrl: RTL

Front-end control stage for the time-setting path of the clock. It conditions five raw inputs (four push-buttons and the edit switch) into the `aum`/`dism`/`en` controls that drive the hour, minute and second counters. It synchronizes and debounces the buttons, turns up/down presses into single-cycle pulses with auto-repeat while held, and tracks which field (hours/minutes/seconds) is being edited. It sits directly upstream of the 0–23 hour counter and its 0–59 siblings, and shares their `clk`.

---
 rtl/time_edit_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/time_edit_ctrl.sv
// Time-setting front end: synchronizes and debounces the edit buttons, produces
// single-cycle up/down pulses with auto-repeat, and tracks the field being edited.
module time_edit_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       edit_mode,
  output logic       aum,
  output logic       dism,
  output logic [2:0] en,
  output logic [1:0] field_sel
);

  localparam int unsigned CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TmrMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TmrW   = (TmrMax > 1) ? $clog2(TmrMax) : 1;

  localparam logic [CntW-1:0] CntLast    = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TmrW-1:0] DelayLoad  = TmrW'(REPEAT_DELAY - 1);
  localparam logic [TmrW-1:0] PeriodLoad = TmrW'(REPEAT_PERIOD - 1);

  localparam int unsigned BUp    = 0;
  localparam int unsigned BDown  = 1;
  localparam int unsigned BLeft  = 2;
  localparam int unsigned BRight = 3;

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;

  logic [3:0]      raw;
  logic [3:0]      sync1;
  logic [3:0]      sync2;
  logic [3:0]      stable;
  logic [3:0]      stable_prev;
  logic [3:0]      armed;
  logic [3:0]      press;
  logic [CntW-1:0] cnt [4];
  logic            edit_s1;
  logic            edit_s2;
  logic [1:0]      fill;

  state_e          state;
  logic            dir_up;
  logic [TmrW-1:0] timer;
  logic            act_stable;

  assign raw        = {btn_right, btn_left, btn_down, btn_up};
  // A button held through reset must be seen released before its rise counts as a press.
  assign press      = stable & ~stable_prev & armed;
  assign act_stable = dir_up ? stable[BUp] : stable[BDown];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= '0;
      sync2       <= '0;
      stable      <= '0;
      stable_prev <= '0;
      armed       <= '0;
      edit_s1     <= 1'b0;
      edit_s2     <= 1'b0;
      fill        <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1       <= raw;
      sync2       <= sync1;
      edit_s1     <= edit_mode;
      edit_s2     <= edit_s1;
      stable_prev <= stable;
      // sync2 only reflects the real pins once the pipeline has refilled after reset
      if (fill != 2'd2) fill <= fill + 2'd1;
      if (fill == 2'd2) armed <= armed | ~sync2;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CntLast) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= StIdle;
      dir_up <= 1'b0;
      timer  <= '0;
      aum    <= 1'b0;
      dism   <= 1'b0;
    end else begin
      aum  <= 1'b0;
      dism <= 1'b0;
      if (!edit_s2 || (stable[BUp] && stable[BDown])) begin
        state <= StIdle;
      end else begin
        case (state)
          StIdle: begin
            if (press[BUp] || press[BDown]) begin
              dir_up <= press[BUp];
              aum    <= press[BUp];
              dism   <= ~press[BUp];
              state  <= StDelay;
              timer  <= DelayLoad;
            end
          end
          StDelay, StRepeat: begin
            if (!act_stable) begin
              state <= StIdle;
            end else if (timer == '0) begin
              aum   <= dir_up;
              dism  <= ~dir_up;
              state <= StRepeat;
              timer <= PeriodLoad;
            end else begin
              timer <= timer - TmrW'(1);
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      field_sel <= 2'd0;
      en        <= 3'b000;
    end else begin
      en <= {edit_s2 && (field_sel == 2'd2),
             edit_s2 && (field_sel == 2'd1),
             edit_s2 && (field_sel == 2'd0)};
      if (edit_s2 && (press[BRight] ^ press[BLeft])) begin
        if (press[BRight]) field_sel <= (field_sel == 2'd2) ? 2'd0 : field_sel + 2'd1;
        else               field_sel <= (field_sel == 2'd0) ? 2'd2 : field_sel - 2'd1;
      end
    end
  end

endmodule
